// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS symbol constants and helper functions
// Purpose: control-token and HDMI guard-band symbols, a ones counter for
//   8-bit values and a {C1,C0} -> control-token lookup, shared by
//   tmds_channel_enc and tmds_video_encoder.
// Ports: none (package).
package tmds_pkg;

  localparam logic [9:0] CTRL_TOKEN_00  = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01  = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10  = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11  = 10'b1010101011;

  localparam logic [9:0] GUARD_RED_BLUE = 10'b1011001100;
  localparam logic [9:0] GUARD_GREEN    = 10'b0100110011;

  function automatic logic [3:0] count_ones8(input logic [7:0] d);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, d[i]};
    end
    return n;
  endfunction

  function automatic logic [9:0] ctrl_token(input logic c1, input logic c0);
    logic [9:0] t;
    case ({c1, c0})
      2'b00:   t = CTRL_TOKEN_00;
      2'b01:   t = CTRL_TOKEN_01;
      2'b10:   t = CTRL_TOKEN_10;
      default: t = CTRL_TOKEN_11;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// rtl/tmds_channel_enc.sv - one TMDS channel: 8b data / 2b control -> 10b symbol
// Purpose: two-stage TMDS encoder for a single colour channel. Stage 1 builds
//   the transition-minimised q_m; stage 2 DC-balances it against the channel's
//   running disparity (cnt) or emits a control token during blanking.
// Ports:
//   pixel_clock  in   clock, rising edge
//   reset        in   asynchronous active-high reset
//   data[7:0]    in   pixel component, used when de=1
//   de           in   data enable
//   c0, c1       in   control bits encoded when de=0
//   symbol[9:0]  out  TMDS symbol, 2 cycles after the inputs
module tmds_channel_enc
  import tmds_pkg::*;
(
  input  logic       pixel_clock,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       de,
  input  logic       c0,
  input  logic       c1,
  output logic [9:0] symbol
);

  logic [3:0]        n1_data;
  logic              use_xnor;
  logic [8:0]        q_m_next;
  logic [8:0]        q_m;
  logic              de_s1;
  logic              c0_s1;
  logic              c1_s1;

  logic [3:0]        n1_q;
  logic signed [4:0] diff;
  logic signed [4:0] cnt;
  logic signed [4:0] cnt_next;
  logic [9:0]        symbol_next;

  // Stage 1: XNOR chaining is chosen for ones-heavy data to cut transitions.
  always_comb begin
    n1_data     = count_ones8(data);
    use_xnor    = (n1_data > 4'd4) || ((n1_data == 4'd4) && !data[0]);
    q_m_next    = '0;
    q_m_next[0] = data[0];
    for (int i = 1; i < 8; i++) begin
      q_m_next[i] = use_xnor ? ~(q_m_next[i-1] ^ data[i]) : (q_m_next[i-1] ^ data[i]);
    end
    q_m_next[8] = ~use_xnor;
  end

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      q_m   <= '0;
      de_s1 <= 1'b0;
      c0_s1 <= 1'b0;
      c1_s1 <= 1'b0;
    end else begin
      q_m   <= q_m_next;
      de_s1 <= de;
      c0_s1 <= c0;
      c1_s1 <= c1;
    end
  end

  // Stage 2: diff is N1-N0 of q_m[7:0] (= 2*N1-8). Blanking forces cnt to 0
  // so every active run starts balanced.
  always_comb begin
    n1_q        = count_ones8(q_m[7:0]);
    diff        = $signed({n1_q, 1'b0} - 5'd8);
    symbol_next = ctrl_token(c1_s1, c0_s1);
    cnt_next    = 5'sd0;
    if (de_s1) begin
      if ((cnt == 5'sd0) || (n1_q == 4'd4)) begin
        symbol_next = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
        cnt_next    = q_m[8] ? (cnt + diff) : (cnt - diff);
      end else if (((cnt > 5'sd0) && (n1_q > 4'd4)) || ((cnt < 5'sd0) && (n1_q < 4'd4))) begin
        symbol_next = {1'b1, q_m[8], ~q_m[7:0]};
        cnt_next    = cnt + $signed({3'b000, q_m[8], 1'b0}) - diff;
      end else begin
        symbol_next = {1'b0, q_m[8], q_m[7:0]};
        cnt_next    = cnt - $signed({3'b000, ~q_m[8], 1'b0}) + diff;
      end
    end
  end

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      symbol <= CTRL_TOKEN_00;
      cnt    <= 5'sd0;
    end else begin
      symbol <= symbol_next;
      cnt    <= cnt_next;
    end
  end

endmodule

// File: rtl/tmds_video_encoder.sv
// rtl/tmds_video_encoder.sv - three-channel DVI/HDMI TMDS video encoder
// Purpose: encodes RGB + hsync/vsync/active into three 10-bit TMDS symbols
//   per pixel_clock. Optional macro VIDEO_GUARD_EN adds a 2-stage input delay
//   so the two blanking symbols before each active run become HDMI video
//   guard-band symbols (latency 4 instead of 2).
// Parameters: SYNC_INVERT - nonzero inverts hsync/vsync before encoding.
// Ports:
//   pixel_clock           in   clock, rising edge
//   reset                 in   asynchronous active-high reset
//   active                in   video data enable
//   hsync, vsync          in   sync, carried as C0/C1 on the blue channel
//   red, green, blue[7:0] in   pixel data
//   tmds_red/green/blue   out  10-bit symbols for channels 2/1/0
//   de_out                out  active aligned with the symbol outputs
module tmds_video_encoder
  import tmds_pkg::*;
#(
  parameter int SYNC_INVERT = 0
) (
  input  logic       pixel_clock,
  input  logic       reset,
  input  logic       active,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  output logic [9:0] tmds_red,
  output logic [9:0] tmds_green,
  output logic [9:0] tmds_blue,
  output logic       de_out
);

  logic       hs_pol;
  logic       vs_pol;
  logic       enc_de;
  logic       enc_hs;
  logic       enc_vs;
  logic [7:0] enc_r;
  logic [7:0] enc_g;
  logic [7:0] enc_b;
  logic       guard_now;
  logic [1:0] de_pipe;
  logic [1:0] guard_pipe;
  logic [9:0] red_sym;
  logic [9:0] green_sym;
  logic [9:0] blue_sym;

  assign hs_pol = (SYNC_INVERT != 0) ? ~hsync : hsync;
  assign vs_pol = (SYNC_INVERT != 0) ? ~vsync : vsync;

`ifdef VIDEO_GUARD_EN
  logic        act_d1;
  logic        act_d2;
  logic [1:0]  sync_d1;
  logic [1:0]  sync_d2;
  logic [23:0] rgb_d1;
  logic [23:0] rgb_d2;

  // The encoder works two samples behind the inputs, so act_d1/active tell
  // it which blanking symbols sit directly in front of an active run.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      act_d1  <= 1'b0;
      act_d2  <= 1'b0;
      sync_d1 <= 2'b00;
      sync_d2 <= 2'b00;
      rgb_d1  <= '0;
      rgb_d2  <= '0;
    end else begin
      act_d1  <= active;
      act_d2  <= act_d1;
      sync_d1 <= {vs_pol, hs_pol};
      sync_d2 <= sync_d1;
      rgb_d1  <= {red, green, blue};
      rgb_d2  <= rgb_d1;
    end
  end

  assign enc_de    = act_d2;
  assign enc_vs    = sync_d2[1];
  assign enc_hs    = sync_d2[0];
  assign enc_r     = rgb_d2[23:16];
  assign enc_g     = rgb_d2[15:8];
  assign enc_b     = rgb_d2[7:0];
  assign guard_now = ~act_d2 & (act_d1 | active);
`else
  assign enc_de    = active;
  assign enc_vs    = vs_pol;
  assign enc_hs    = hs_pol;
  assign enc_r     = red;
  assign enc_g     = green;
  assign enc_b     = blue;
  assign guard_now = 1'b0;
`endif

  // Matches the two register stages inside each channel encoder.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      de_pipe    <= 2'b00;
      guard_pipe <= 2'b00;
    end else begin
      de_pipe    <= {de_pipe[0], enc_de};
      guard_pipe <= {guard_pipe[0], guard_now};
    end
  end

  assign de_out = de_pipe[1];

  tmds_channel_enc u_red (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .data        (enc_r),
    .de          (enc_de),
    .c0          (1'b0),
    .c1          (1'b0),
    .symbol      (red_sym)
  );

  tmds_channel_enc u_green (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .data        (enc_g),
    .de          (enc_de),
    .c0          (1'b0),
    .c1          (1'b0),
    .symbol      (green_sym)
  );

  tmds_channel_enc u_blue (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .data        (enc_b),
    .de          (enc_de),
    .c0          (enc_hs),
    .c1          (enc_vs),
    .symbol      (blue_sym)
  );

  // guard_pipe is only ever set on blanking samples, so pixels are never replaced.
  assign tmds_red   = guard_pipe[1] ? GUARD_RED_BLUE : red_sym;
  assign tmds_green = guard_pipe[1] ? GUARD_GREEN    : green_sym;
  assign tmds_blue  = guard_pipe[1] ? GUARD_RED_BLUE : blue_sym;

endmodule

// File: tb/tb_tmds_video_encoder.sv
// tb/tb_tmds_video_encoder.sv - self-checking bench for tmds_video_encoder
module tb_tmds_video_encoder;

`ifdef VIDEO_GUARD_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic       pixel_clock;
  logic       reset;
  logic       active;
  logic       hsync;
  logic       vsync;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic [9:0] tmds_red;
  logic [9:0] tmds_green;
  logic [9:0] tmds_blue;
  logic       de_out;

  int test_count = 0;
  int fail_count = 0;
  int cnt_r = 0;
  int cnt_g = 0;
  int cnt_b = 0;

  typedef struct packed {
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
    logic       de;
  } exp_t;

  exp_t exp_q[$];

  tmds_video_encoder #(.SYNC_INVERT(0)) dut (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .active      (active),
    .hsync       (hsync),
    .vsync       (vsync),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .tmds_red    (tmds_red),
    .tmds_green  (tmds_green),
    .tmds_blue   (tmds_blue),
    .de_out      (de_out)
  );

  initial pixel_clock = 1'b0;
  always #5 pixel_clock = ~pixel_clock;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    test_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] tok(input logic [1:0] c);
    case (c)
      2'b00:   return 10'h354;
      2'b01:   return 10'h0AB;
      2'b10:   return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  // Reference: balance tracked as ones-minus-zeros of every transmitted symbol.
  function automatic logic [9:0] model_sym(input logic [7:0] d, input int cnt_in, output int cnt_out);
    int         n1;
    int         k;
    logic       use_xnor;
    logic [7:0] qm;
    logic       q8;
    logic       invert;
    logic [9:0] s;
    n1       = $countones(d);
    use_xnor = (n1 > 4) || ((n1 == 4) && (d[0] == 1'b0));
    qm       = 8'h00;
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    q8 = ~use_xnor;
    k  = $countones(qm);
    if ((cnt_in == 0) || (k == 4)) invert = ~q8;
    else if (((cnt_in > 0) && (k > 4)) || ((cnt_in < 0) && (k < 4))) invert = 1'b1;
    else invert = 1'b0;
    s       = {invert, q8, invert ? ~qm : qm};
    cnt_out = cnt_in + 2 * $countones(s) - 10;
    return s;
  endfunction

  // Drive one pixel period, then compare the outputs due at this point.
  task automatic cyc(input logic act, input logic hs, input logic vs,
                     input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    exp_t e;
    exp_t p;
    int   nc;
    active = act;
    hsync  = hs;
    vsync  = vs;
    red    = r;
    green  = g;
    blue   = b;
    e.de   = act;
    if (act) begin
      e.r = model_sym(r, cnt_r, nc); cnt_r = nc;
      e.g = model_sym(g, cnt_g, nc); cnt_g = nc;
      e.b = model_sym(b, cnt_b, nc); cnt_b = nc;
`ifdef VIDEO_GUARD_EN
      for (int k = 1; k <= 2; k++) begin
        if (exp_q.size() >= k) begin
          p = exp_q[exp_q.size() - k];
          if (!p.de) begin
            p.r = 10'h2CC;
            p.g = 10'h133;
            p.b = 10'h2CC;
            exp_q[exp_q.size() - k] = p;
          end
        end
      end
`endif
    end else begin
      e.r = 10'h354;
      e.g = 10'h354;
      e.b = tok({vs, hs});
      cnt_r = 0;
      cnt_g = 0;
      cnt_b = 0;
    end
    exp_q.push_back(e);
    @(negedge pixel_clock);
    if (exp_q.size() >= LAT) begin
      e = exp_q.pop_front();
      chk("sb_red",   tmds_red,   e.r);
      chk("sb_green", tmds_green, e.g);
      chk("sb_blue",  tmds_blue,  e.b);
      chk("sb_de",    {9'd0, de_out}, {9'd0, e.de});
    end
  endtask

  initial begin
    reset  = 1'b1;
    active = 1'b0;
    hsync  = 1'b0;
    vsync  = 1'b0;
    red    = 8'h00;
    green  = 8'h00;
    blue   = 8'h00;

    repeat (3) @(negedge pixel_clock);
    chk("rst_red",   tmds_red,   10'h354);
    chk("rst_green", tmds_green, 10'h354);
    chk("rst_blue",  tmds_blue,  10'h354);
    chk("rst_de",    {9'd0, de_out}, 10'd0);
    reset = 1'b0;

    // Control tokens on blue, red/green stay 00 token.
    for (int s = 0; s < 4; s++) begin
      repeat (LAT + 1) cyc(1'b0, s[0], s[1], 8'h5A, 8'hA5, 8'h3C);
      chk("ctl_blue",  tmds_blue,  tok(2'(s)));
      chk("ctl_red",   tmds_red,   10'h354);
      chk("ctl_green", tmds_green, 10'h354);
      chk("ctl_de",    {9'd0, de_out}, 10'd0);
    end

    // Two pixels after blanking: red=FF, green=blue=00.
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00);
    repeat (LAT - 2) cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("px1_red",   tmds_red,   10'h200);
    chk("px1_green", tmds_green, 10'h100);
    chk("px1_blue",  tmds_blue,  10'h100);
    chk("px1_de",    {9'd0, de_out}, 10'd1);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("px2_red",   tmds_red,   10'h0FF);
    chk("px2_green", tmds_green, 10'h3FF);
    chk("px2_blue",  tmds_blue,  10'h3FF);
    chk("px2_de",    {9'd0, de_out}, 10'd1);
    repeat (LAT + 2) cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

`ifdef VIDEO_GUARD_EN
    repeat (10) cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00);
    chk("gb_pre_red", tmds_red, 10'h354);
    cyc(1'b1, 1'b0, 1'b0, 8'h12, 8'h34, 8'h56);
    chk("gb1_red",   tmds_red,   10'h2CC);
    chk("gb1_green", tmds_green, 10'h133);
    chk("gb1_blue",  tmds_blue,  10'h2CC);
    cyc(1'b1, 1'b0, 1'b0, 8'h78, 8'h9A, 8'hBC);
    chk("gb2_red",   tmds_red,   10'h2CC);
    chk("gb2_green", tmds_green, 10'h133);
    chk("gb2_de",    {9'd0, de_out}, 10'd0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("gb_px_red", tmds_red,   10'h200);
    chk("gb_px_de",  {9'd0, de_out}, 10'd1);
    repeat (LAT + 2) cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
`endif

    // Random lines with varied blanking, including a single-cycle gap.
    for (int ln = 0; ln < 4; ln++) begin
      int blank_len;
      blank_len = (ln == 1) ? 1 : ((ln == 2) ? 3 : 12);
      for (int i = 0; i < blank_len; i++)
        cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      for (int i = 0; i < 640; i++)
        cyc(1'b1, 1'b0, 1'b0,
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    repeat (LAT + 2) cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);

    // Reset in the middle of an active run.
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    repeat (8) cyc(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)), 8'hFF, 8'h0F);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_red",   tmds_red,   10'h354);
    chk("mid_rst_green", tmds_green, 10'h354);
    chk("mid_rst_blue",  tmds_blue,  10'h354);
    chk("mid_rst_de",    {9'd0, de_out}, 10'd0);
    repeat (2) @(negedge pixel_clock);
    chk("hold_rst_blue", tmds_blue, 10'h354);
    chk("hold_rst_de",   {9'd0, de_out}, 10'd0);
    exp_q.delete();
    cnt_r = 0;
    cnt_g = 0;
    cnt_b = 0;
    active = 1'b0;
    reset  = 1'b0;
    repeat (4) cyc(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    repeat (20) cyc(1'b1, 1'b0, 1'b0,
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    repeat (LAT + 2) cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
